// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
// Opcodes, flag bit positions and the flag masking rule.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    // Carry and overflow only mean something for ADD and SUB.
    function automatic flags_t mask_flags(
        input logic [OP_W-1:0] op,
        input flags_t          f
    );
        flags_t m;
        m = f;
        if (op != OP_ADD && op != OP_SUB) begin
            m[FLAG_C] = 1'b0;
            m[FLAG_V] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Small synchronous FIFO with a registered head entry.
// The head register holds its last value once the FIFO drains.
module alu_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rnext;
    logic [W-1:0]  head;
    logic [W-1:0]  head_nxt;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rnext   = rptr + AW'(1);
    assign rdata   = head;

    // Next head: the following stored entry, or the incoming one
    // when it is the only entry left after this cycle.
    always_comb begin
        head_nxt = head;
        if (do_pop) begin
            if (level > LW'(1)) begin
                head_nxt = mem[rnext];
            end else if (do_push) begin
                head_nxt = wdata;
            end
        end else if (empty && do_push) begin
            head_nxt = wdata;
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            head  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rnext;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            head <= head_nxt;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the ALU: masks flags, queues results,
// and tracks sticky flags plus a count of accepted operations.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_opcode,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carry,
    input  logic                     in_zero,
    input  logic                     in_overflow,
    input  logic                     in_sign,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          out_opcode,
    output logic [WIDTH-1:0]         out_result,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [FLAG_W-1:0]        sticky_flags,
    input  logic                     sticky_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         op_count
);

    localparam int PW = OP_W + WIDTH + FLAG_W;

    flags_t        raw_flags;
    flags_t        masked;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [PW-1:0] wdata;
    logic [PW-1:0] rdata;

    // Gather the ALU flags into one vector and apply masking.
    always_comb begin
        raw_flags         = '0;
        raw_flags[FLAG_C] = in_carry;
        raw_flags[FLAG_Z] = in_zero;
        raw_flags[FLAG_V] = in_overflow;
        raw_flags[FLAG_S] = in_sign;
        masked            = mask_flags(in_opcode, raw_flags);
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wdata     = {in_opcode, in_result, masked};

    assign out_opcode = rdata[PW-1 -: OP_W];
    assign out_result = rdata[FLAG_W +: WIDTH];
    assign out_flags  = rdata[FLAG_W-1:0];

    alu_sync_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Sticky flags accumulate accepted flags; clear wins over history only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (sticky_clr ? '0 : sticky_flags)
                          | (push ? masked : '0);
        end
    end

    // Count accepted entries, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (push) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage.
// Directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_stage;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [7:0] in_result;
    logic       in_carry;
    logic       in_zero;
    logic       in_overflow;
    logic       in_sign;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_opcode;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] sticky_flags;
    logic       sticky_clr;
    logic [2:0] level;
    logic [15:0] op_count;

    int n_chk  = 0;
    int n_fail = 0;

    alu_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_sign      (in_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .level        (level),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of {opcode, result, flags} entries.
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] res;
        logic [3:0] fl;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_sticky = '0;
    logic [15:0] m_cnt    = '0;
    bit          m_push;
    bit          m_pop;
    logic [3:0]  m_fl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sticky = '0;
            m_cnt    = '0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = out_ready && (mq.size() > 0);
            m_fl   = {in_carry, in_zero, in_overflow, in_sign};
            if (in_opcode > 4'd1) begin
                m_fl[3] = 1'b0;
                m_fl[1] = 1'b0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{in_opcode, in_result, m_fl});
            m_sticky = (sticky_clr ? 4'b0 : m_sticky) | (m_push ? m_fl : 4'b0);
            if (m_push) m_cnt = m_cnt + 16'd1;
        end
    end

    // Compare DUT against the model once per cycle, away from the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("sticky", 32'(sticky_flags), 32'(m_sticky));
            chk("op_count", 32'(op_count), 32'(m_cnt));
            if (mq.size() != 0) begin
                chk("head", 32'({out_opcode, out_result, out_flags}),
                    32'(mq[0]));
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [7:0] res, input logic [3:0] fl,
                         input logic rdy, input logic clr);
        in_valid    = v;
        in_opcode   = op;
        in_result   = res;
        in_carry    = fl[3];
        in_zero     = fl[2];
        in_overflow = fl[1];
        in_sign     = fl[0];
        out_ready   = rdy;
        sticky_clr  = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 4'd0, 8'h00, 4'b0000, 0, 0);
        #3;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst level", 32'(level), 0);
        chk("rst sticky", 32'(sticky_flags), 0);
        chk("rst op_count", 32'(op_count), 0);
        chk("rst head", 32'({out_opcode, out_result, out_flags}), 0);
        step();
        rst_n = 1'b1;
        chk("rst in_ready", 32'(in_ready), 1);

        // Single push, then masked-flag push with a same-cycle pop.
        drive(1, 4'd0, 8'h80, 4'b0011, 0, 0);
        step();
        chk("p1 valid", 32'(out_valid), 1);
        chk("p1 result", 32'(out_result), 32'h80);
        chk("p1 flags", 32'(out_flags), 32'b0011);
        chk("p1 sticky", 32'(sticky_flags), 32'b0011);
        chk("p1 level", 32'(level), 1);
        chk("p1 count", 32'(op_count), 1);
        drive(1, 4'd2, 8'h00, 4'b1110, 1, 0);
        step();
        chk("p2 flags", 32'(out_flags), 32'b0100);
        chk("p2 opcode", 32'(out_opcode), 2);
        chk("p2 level", 32'(level), 1);
        chk("p2 sticky", 32'(sticky_flags), 32'b0111);
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        step();
        chk("p2 drained", 32'(level), 0);

        // Fill to full, try a fifth push, then drain in order.
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'd3, 8'(8'h11 * (k + 1)), 4'b0000, 0, 0);
            step();
        end
        chk("full level", 32'(level), 4);
        chk("full in_ready", 32'(in_ready), 0);
        chk("full head", 32'(out_result), 32'h11);
        drive(1, 4'd3, 8'h55, 4'b0000, 0, 0);
        step();
        chk("full hold level", 32'(level), 4);
        chk("full hold head", 32'(out_result), 32'h11);
        chk("full hold count", 32'(op_count), 6);
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain head", 32'(out_result), 32'(8'h11 * (k + 1)));
            step();
        end
        chk("drain empty", 32'(out_valid), 0);

        // Steady stream at level 2 across pointer wrap.
        for (int k = 0; k < 2; k++) begin
            drive(1, 4'd0, 8'(8'hA0 + k), 4'b0000, 0, 0);
            step();
        end
        for (int i = 1; i <= 12; i++) begin
            drive(1, 4'd1, 8'(8'hA0 + i + 1), 4'b0000, 1, 0);
            step();
            chk("stream level", 32'(level), 2);
            chk("stream head", 32'(out_result), 32'(8'hA0 + i));
        end
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        step();
        step();

        // Sticky clear behaviour.
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 1);
        step();
        chk("clr sticky", 32'(sticky_flags), 0);
        drive(1, 4'd0, 8'h01, 4'b1000, 1, 0);
        step();
        chk("sticky C", 32'(sticky_flags), 32'b1000);
        drive(1, 4'd1, 8'h02, 4'b0010, 1, 1);
        step();
        chk("clr+push sticky", 32'(sticky_flags), 32'b0010);
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 1);
        step();
        chk("clr alone", 32'(sticky_flags), 0);
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        step();

        // Randomized traffic with phases of back-pressure.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 50) % 3;
            drive(($urandom % 4) != 0,
                  4'($urandom % 16),
                  8'($urandom),
                  4'($urandom),
                  bias == 0 ? (($urandom % 4) == 0) :
                  bias == 1 ? (($urandom % 4) != 0) :
                              1'($urandom),
                  ($urandom % 16) == 0);
            step();
        end

        // Asynchronous reset with three entries queued.
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        for (int k = 0; k < 5; k++) step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'd0, 8'(8'h30 + k), 4'b0001, 0, 0);
            step();
        end
        chk("pre-rst level", 32'(level), 3);
        drive(0, 4'd0, 8'h00, 4'b0000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 0);
        chk("arst level", 32'(level), 0);
        chk("arst sticky", 32'(sticky_flags), 0);
        chk("arst count", 32'(op_count), 0);
        rst_n = 1'b1;
        step();
        drive(1, 4'd0, 8'h5A, 4'b0000, 0, 0);
        step();
        chk("post-rst valid", 32'(out_valid), 1);
        chk("post-rst result", 32'(out_result), 32'h5A);
        chk("post-rst count", 32'(op_count), 1);
        chk("post-rst level", 32'(level), 1);
        drive(0, 4'd0, 8'h00, 4'b0000, 1, 0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
